// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage pipeline: drives latch en/flush pairs and PC enable.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_control #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_pcsrc,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_Rt,
    input  logic [REG_W-1:0] id_Rs,
    input  logic [REG_W-1:0] id_Rt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_en,
    output logic             de_flush,
    output logic             em_en,
    output logic             em_flush,
    output logic             mw_en,
    output logic             mw_flush,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   mem_busy_s;
    logic   lu_haz_s;
    logic   pc_en_s, fd_en_s, fd_flush_s, de_en_s, de_flush_s;
    logic   em_en_s, em_flush_s, mw_en_s, mw_flush_s;

    assign mem_busy_s = (mem_dREN | mem_dWEN) & ~dhit;
    assign lu_haz_s   = ex_dREN & (ex_Rt != {REG_W{1'b0}}) &
                        ((ex_Rt == id_Rs) | (ex_Rt == id_Rt));

    // State register; HALTED is only left through reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Priority decode of latch controls and next state.
    always_comb begin
        state_next_s = state_r;
        pc_en_s      = 1'b0;
        fd_en_s      = 1'b0;
        fd_flush_s   = 1'b0;
        de_en_s      = 1'b0;
        de_flush_s   = 1'b0;
        em_en_s      = 1'b0;
        em_flush_s   = 1'b0;
        mw_en_s      = 1'b0;
        mw_flush_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (wb_halt) begin
                    state_next_s = HALTED;
                end else if (mem_busy_s) begin
                    state_next_s = RUN;
                end else if (mem_pcsrc) begin
                    // The branch in memory retires; everything younger is squashed.
                    pc_en_s    = 1'b1;
                    fd_en_s    = 1'b1;
                    fd_flush_s = 1'b1;
                    de_en_s    = 1'b1;
                    de_flush_s = 1'b1;
                    em_en_s    = 1'b1;
                    em_flush_s = 1'b1;
                    mw_en_s    = 1'b1;
                end else if (!ihit) begin
                    fd_en_s    = 1'b1;
                    fd_flush_s = 1'b1;
                    de_en_s    = 1'b1;
                    em_en_s    = 1'b1;
                    mw_en_s    = 1'b1;
                end else if (lu_haz_s) begin
                    de_en_s    = 1'b1;
                    de_flush_s = 1'b1;
                    em_en_s    = 1'b1;
                    mw_en_s    = 1'b1;
                end else begin
                    pc_en_s    = 1'b1;
                    fd_en_s    = 1'b1;
                    de_en_s    = 1'b1;
                    em_en_s    = 1'b1;
                    mw_en_s    = 1'b1;
                end
            end
            HALTED: begin
                state_next_s = HALTED;
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // Controls are same-cycle but forced low while reset is held.
    assign pc_en    = pc_en_s    & nRST;
    assign fd_en    = fd_en_s    & nRST;
    assign fd_flush = fd_flush_s & nRST;
    assign de_en    = de_en_s    & nRST;
    assign de_flush = de_flush_s & nRST;
    assign em_en    = em_en_s    & nRST;
    assign em_flush = em_flush_s & nRST;
    assign mw_en    = mw_en_s    & nRST;
    assign mw_flush = mw_flush_s & nRST;
    assign halted   = (state_r == HALTED);

`ifdef PIPE_PERF_CNT_EN
    logic             stall_s;
    logic             flush_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Classify the current RUN cycle for the counters.
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        if ((state_r == RUN) && !wb_halt) begin
            stall_s = mem_busy_s | (!mem_pcsrc & (!ihit | lu_haz_s));
            flush_s = !mem_busy_s & mem_pcsrc;
        end else begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end
    end

    // Saturating activity counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: priority-rule model checked every negedge
// plus directed vectors with hand-computed control words.
module tb_pipeline_control;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    logic CLK = 1'b0;
    logic nRST;
    logic ihit, dhit, mem_dREN, mem_dWEN, mem_pcsrc, ex_dREN, wb_halt;
    logic [REG_W-1:0] ex_Rt, id_Rs, id_Rt;
    logic pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush;
    logic halted;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [CNT_W-1:0] m_stall, m_flush;
`endif

    int tests = 0;
    int fails = 0;
    logic m_halted;

    pipeline_control #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_pcsrc(mem_pcsrc),
        .ex_dREN(ex_dREN), .ex_Rt(ex_Rt), .id_Rs(id_Rs), .id_Rt(id_Rt),
        .wb_halt(wb_halt), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
        .de_en(de_en), .de_flush(de_flush), .em_en(em_en), .em_flush(em_flush),
        .mw_en(mw_en), .mw_flush(mw_flush),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Word order: {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush}
    function automatic logic [8:0] dut_word();
        return {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush};
    endfunction

    function automatic logic busy_now();
        return (mem_dREN | mem_dWEN) & ~dhit;
    endfunction

    function automatic logic haz_now();
        return ex_dREN && (ex_Rt != 5'd0) && (ex_Rt == id_Rs || ex_Rt == id_Rt);
    endfunction

    function automatic logic [8:0] model_word();
        if (!nRST || m_halted || wb_halt || busy_now()) return 9'b000000000;
        if (mem_pcsrc) return 9'b111111110;
        if (!ihit)     return 9'b011101010;
        if (haz_now()) return 9'b000111010;
        return 9'b110101010;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference state: halt latch and counters follow the spec rules.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_halted <= 1'b0;
`ifdef PIPE_PERF_CNT_EN
            m_stall <= '0;
            m_flush <= '0;
`endif
        end else if (!m_halted) begin
            if (wb_halt) m_halted <= 1'b1;
`ifdef PIPE_PERF_CNT_EN
            else if (busy_now() || (!mem_pcsrc && (!ihit || haz_now()))) begin
                if (m_stall != '1) m_stall <= m_stall + 1;
            end else if (mem_pcsrc) begin
                if (m_flush != '1) m_flush <= m_flush + 1;
            end
`endif
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        check("model_ctrl", 64'(dut_word()), 64'(model_word()));
        check("model_halted", 64'(halted), 64'(m_halted));
`ifdef PIPE_PERF_CNT_EN
        check("model_stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("model_flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end

    task automatic step(input string nm, input logic [8:0] exp_w, input logic exp_h);
        #3;
        check(nm, 64'(dut_word()), 64'(exp_w));
        check({nm, "_halted"}, 64'(halted), 64'(exp_h));
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_pcsrc = 1'b0; ex_dREN = 1'b0; wb_halt = 1'b0;
        ex_Rt = 5'd0; id_Rs = 5'd0; id_Rt = 5'd0;
    endtask

    initial begin
        nRST = 1'b0;
        clear_inputs();
        #3;
        check("reset_ctrl", 64'(dut_word()), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        step("free_run", 9'b110101010, 1'b0);
        ex_dREN = 1'b1; ex_Rt = 5'd5; id_Rs = 5'd5;
        step("lu_haz_rs", 9'b000111010, 1'b0);
        id_Rs = 5'd3; id_Rt = 5'd5;
        step("lu_haz_rt", 9'b000111010, 1'b0);
        ex_Rt = 5'd0; id_Rs = 5'd0; id_Rt = 5'd0;
        step("reg0_no_haz", 9'b110101010, 1'b0);
        clear_inputs(); ihit = 1'b0;
        step("imiss", 9'b011101010, 1'b0);
        ex_dREN = 1'b1; ex_Rt = 5'd7; id_Rt = 5'd7;
        step("imiss_over_haz", 9'b011101010, 1'b0);
        clear_inputs(); mem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) step("dmiss_freeze", 9'b000000000, 1'b0);
        dhit = 1'b1;
        step("dhit_release", 9'b110101010, 1'b0);
        clear_inputs(); mem_dWEN = 1'b1;
        step("dwrite_freeze", 9'b000000000, 1'b0);
        clear_inputs(); mem_pcsrc = 1'b1; ihit = 1'b0;
        ex_dREN = 1'b1; ex_Rt = 5'd9; id_Rs = 5'd9;
        step("redirect", 9'b111111110, 1'b0);
        mem_dREN = 1'b1;
        step("busy_over_redirect", 9'b000000000, 1'b0);
        clear_inputs(); wb_halt = 1'b1; mem_dREN = 1'b1;
        step("halt_with_busy", 9'b000000000, 1'b0);
        clear_inputs();
        step("halted_1", 9'b000000000, 1'b1);
`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt_lit", 64'(stall_cnt), 64'd9);
        check("flush_cnt_lit", 64'(flush_cnt), 64'd1);
`endif
        step("halted_2", 9'b000000000, 1'b1);

        nRST = 1'b0;
        #2;
        check("rst_mid_halt_halted", 64'(halted), 64'd0);
        check("rst_mid_halt_ctrl", 64'(dut_word()), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step("after_reset_run", 9'b110101010, 1'b0);
        mem_pcsrc = 1'b1;
        step("redirect_after_reset", 9'b111111110, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
